// File: rtl/ctrl_dec_multi.sv
// ctrl_dec_multi: N_CH independent decimation channels on one emulator clock.
// Each channel divides run cycles by (thr_act+1) and emits a one-cycle strobe.
// New thresholds are staged in thr_pend and take effect only at a wrap or on
// a global sync, so a period is never cut short or stretched mid-flight.
// Optional feature macro DEC_TSTAMP_EN: capture emu_time at each channel wrap.
// When the macro is undefined, emu_dec_stamp is constant zero.
module ctrl_dec_multi #(
  parameter int N_CH       = 4,
  parameter int DEC_WIDTH  = 32,
  parameter int TIME_WIDTH = 64
) (
  input  logic                       emu_clk,
  input  logic                       emu_rst_n,
  input  logic [TIME_WIDTH-1:0]      emu_time,
  input  logic [N_CH*DEC_WIDTH-1:0]  emu_dec_thr,
  input  logic [N_CH-1:0]            thr_load,
  input  logic                       run,
  input  logic                       sync,
  output logic [N_CH-1:0]            emu_dec_cmp,
  output logic [N_CH*TIME_WIDTH-1:0] emu_dec_stamp
);

  logic [DEC_WIDTH-1:0] cnt      [N_CH];
  logic [DEC_WIDTH-1:0] thr_act  [N_CH];
  logic [DEC_WIDTH-1:0] thr_pend [N_CH];
  logic [N_CH-1:0]      pend;
  logic [N_CH-1:0]      wrap;

  // Wrap condition per channel; sync overrides any wrap on the same edge.
  always_comb begin
    // NOTE: default assignment first so no path leaves wrap unassigned (no latch).
    wrap = '0;
    for (int i = 0; i < N_CH; i++) begin
      wrap[i] = run && !sync && (cnt[i] == thr_act[i]);
    end
  end

  // Per-channel counter, threshold staging and strobe register.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      // NOTE: these small register arrays are reset element by element; they are
      // control state, not RAM, so an asynchronous clear is required and cheap.
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]      <= '0;
        thr_act[i]  <= '0;
        thr_pend[i] <= '0;
      end
      pend        <= '0;
      emu_dec_cmp <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync) begin
          // Realign phase; any staged or simultaneously loaded value goes live now.
          // NOTE: non-blocking assignments so every channel sees pre-edge state.
          cnt[i]         <= '0;
          emu_dec_cmp[i] <= 1'b0;
          pend[i]        <= 1'b0;
          if (thr_load[i]) begin
            thr_act[i]  <= emu_dec_thr[i*DEC_WIDTH +: DEC_WIDTH];
            thr_pend[i] <= emu_dec_thr[i*DEC_WIDTH +: DEC_WIDTH];
          end else if (pend[i]) begin
            thr_act[i] <= thr_pend[i];
          end
        end else begin
          emu_dec_cmp[i] <= wrap[i];
          if (run) begin
            cnt[i] <= wrap[i] ? '0 : cnt[i] + 1'b1;
          end
          if (wrap[i] && pend[i]) begin
            thr_act[i] <= thr_pend[i];
            pend[i]    <= 1'b0;
          end
          // A load on a wrap edge stays pending for the following wrap.
          if (thr_load[i]) begin
            thr_pend[i] <= emu_dec_thr[i*DEC_WIDTH +: DEC_WIDTH];
            pend[i]     <= 1'b1;
          end
        end
      end
    end
  end

`ifdef DEC_TSTAMP_EN
  logic [TIME_WIDTH-1:0] stamp [N_CH];

  // Capture emu_time on each wrap edge; sync leaves stamps untouched.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        stamp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wrap[i]) begin
          stamp[i] <= emu_time;
        end
      end
    end
  end

  // Pack the per-channel stamps onto the output bus.
  always_comb begin
    emu_dec_stamp = '0;
    for (int i = 0; i < N_CH; i++) begin
      emu_dec_stamp[i*TIME_WIDTH +: TIME_WIDTH] = stamp[i];
    end
  end
`else
  logic stamp_unused;
  assign stamp_unused  = ^emu_time;
  assign emu_dec_stamp = '0;
`endif

endmodule

// File: tb/tb_ctrl_dec_multi.sv
// Scoreboard bench for ctrl_dec_multi: a behavioural channel model predicts
// each edge's strobes/stamps when inputs are driven; the DUT is compared after
// the edge. Directed strobe counts cross-check the model against fixed numbers.
module tb_ctrl_dec_multi;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int TW  = 64;

  logic                emu_clk = 1'b0;
  logic                emu_rst_n;
  logic [TW-1:0]       emu_time;
  logic [NCH*DW-1:0]   emu_dec_thr;
  logic [NCH-1:0]      thr_load;
  logic                run;
  logic                sync;
  logic [NCH-1:0]      emu_dec_cmp;
  logic [NCH*TW-1:0]   emu_dec_stamp;

  ctrl_dec_multi #(.N_CH(NCH), .DEC_WIDTH(DW), .TIME_WIDTH(TW)) dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .emu_time(emu_time),
    .emu_dec_thr(emu_dec_thr), .thr_load(thr_load), .run(run), .sync(sync),
    .emu_dec_cmp(emu_dec_cmp), .emu_dec_stamp(emu_dec_stamp)
  );

  always #5 emu_clk = ~emu_clk;

  typedef struct packed {
    logic [NCH-1:0]    cmp;
    logic [NCH*TW-1:0] stamp;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int strobes [NCH];
  int cyc = 0;

  // Reference model state.
  int unsigned m_cnt  [NCH];
  int unsigned m_act  [NCH];
  int unsigned m_pv   [NCH];
  bit          m_pend [NCH];
  logic [TW-1:0] m_stamp [NCH];

  task automatic check(input string tag, input logic [NCH*TW-1:0] got,
                       input logic [NCH*TW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_act[i] = 0; m_pv[i] = 0; m_pend[i] = 0; m_stamp[i] = '0;
    end
  endtask

  task automatic clear_strobes();
    for (int i = 0; i < NCH; i++) strobes[i] = 0;
  endtask

  // Drive one cycle's inputs, predict, clock, compare.
  task automatic step(input bit r, input bit s, input logic [NCH-1:0] ld,
                      input logic [NCH*DW-1:0] thr);
    exp_t e;
    exp_t got;
    @(negedge emu_clk);
    run = r; sync = s; thr_load = ld; emu_dec_thr = thr;
    emu_time = 64'd1000 + 64'(cyc);
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      int unsigned v;
      bit w;
      v = thr[i*DW +: DW];
      if (s) begin
        m_cnt[i] = 0;
        if (ld[i]) begin
          m_act[i] = v; m_pv[i] = v;
        end else if (m_pend[i]) begin
          m_act[i] = m_pv[i];
        end
        m_pend[i] = 0;
      end else begin
        w = r && (m_cnt[i] == m_act[i]);
        e.cmp[i] = w;
        if (r) m_cnt[i] = w ? 0 : m_cnt[i] + 1;
`ifdef DEC_TSTAMP_EN
        if (w) m_stamp[i] = emu_time;
`endif
        if (w && m_pend[i]) begin
          m_act[i] = m_pv[i]; m_pend[i] = 0;
        end
        if (ld[i]) begin
          m_pv[i] = v; m_pend[i] = 1;
        end
      end
      e.stamp[i*TW +: TW] = m_stamp[i];
    end
    exp_q.push_back(e);
    @(posedge emu_clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      got = exp_q.pop_front();
      check("cmp", {{(NCH*TW-NCH){1'b0}}, emu_dec_cmp}, {{(NCH*TW-NCH){1'b0}}, got.cmp});
      check("stamp", emu_dec_stamp, got.stamp);
    end
    for (int i = 0; i < NCH; i++) if (emu_dec_cmp[i]) strobes[i]++;
  endtask

  function automatic logic [NCH*DW-1:0] thr_ch(input int ch, input int unsigned v);
    logic [NCH*DW-1:0] t;
    t = '0;
    t[ch*DW +: DW] = v;
    return t;
  endfunction

  initial begin
    logic [NCH*DW-1:0] rthr;
    bit found;
    emu_rst_n = 1'b0; run = 0; sync = 0; thr_load = '0; emu_dec_thr = '0;
    emu_time = 64'd1000;
    model_reset();
    clear_strobes();
    #12;
    check("rst_cmp", {{(NCH*TW-NCH){1'b0}}, emu_dec_cmp}, '0);
    check("rst_stamp", emu_dec_stamp, '0);
    @(negedge emu_clk);
    emu_rst_n = 1'b1;

    // Load thr=3 on ch0, sync, then run: ch0 every 4, others every cycle.
    step(0, 0, 4'b0001, thr_ch(0, 3));
    step(0, 1, 4'b0000, '0);
    clear_strobes();
    for (int k = 0; k < 12; k++) step(1, 0, '0, '0);
    check("dir_ch0_period4", 32'(strobes[0]), 32'd3);
    check("dir_ch1_every", 32'(strobes[1]), 32'd12);

    // ch2 thr=2, at cnt=1 load 5: old period finishes, then period 6.
    step(0, 1, 4'b0100, thr_ch(2, 2));
    step(1, 0, '0, '0);
    step(1, 0, 4'b0100, thr_ch(2, 5));
    clear_strobes();
    step(1, 0, '0, '0);
    check("dir_ch2_oldper", 32'(strobes[2]), 32'd1);
    clear_strobes();
    for (int k = 0; k < 12; k++) step(1, 0, '0, '0);
    check("dir_ch2_period6", 32'(strobes[2]), 32'd2);

    // ch0 thr=3 paused at cnt=2 for 10 cycles.
    step(0, 1, '0, '0);
    step(1, 0, '0, '0);
    step(1, 0, '0, '0);
    clear_strobes();
    for (int k = 0; k < 10; k++) step(0, 0, '0, '0);
    check("dir_pause_none", 32'(strobes[0] + strobes[1]), 32'd0);
    step(1, 0, '0, '0);
    check("dir_resume_wait", 32'(strobes[0]), 32'd0);
    step(1, 0, '0, '0);
    check("dir_resume_strobe", 32'(strobes[0]), 32'd1);

    // ch1: pending 2, then load 7 together with sync -> period 8 at once.
    step(0, 0, 4'b0010, thr_ch(1, 2));
    step(0, 1, 4'b0010, thr_ch(1, 7));
    clear_strobes();
    for (int k = 0; k < 16; k++) step(1, 0, '0, '0);
    check("dir_ch1_period8", 32'(strobes[1]), 32'd2);

    // Random traffic with small thresholds.
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < NCH; i++) rthr[i*DW +: DW] = $urandom_range(0, 6);
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 29) == 0),
           NCH'($urandom_range(0, 15) & $urandom_range(0, 15)), rthr);
    end

    // Async reset while a strobe is high.
    step(0, 1, 4'b1000, thr_ch(3, 0));
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(1, 0, '0, '0);
      if (emu_dec_cmp != '0) found = 1;
    end
    check("rst_find_strobe", {255'd0, found}, {255'd0, 1'b1});
    #2;
    emu_rst_n = 1'b0;
    #1;
    check("async_rst_cmp", {{(NCH*TW-NCH){1'b0}}, emu_dec_cmp}, '0);
    check("async_rst_stamp", emu_dec_stamp, '0);
    model_reset();
    @(negedge emu_clk);
    emu_rst_n = 1'b1;
    clear_strobes();
    for (int k = 0; k < 4; k++) step(1, 0, '0, '0);
    check("post_rst_every", 32'(strobes[0] + strobes[1] + strobes[2] + strobes[3]), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
